clock_switch_ctrl: RTL and testbench

//  Sequencer that drives the sel input of glitch_free_mux from an always-on

---
 rtl/clock_switch_ctrl.sv | 141 ++++++++++++++
 tb/tb_clock_switch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_ctrl.sv
// Sequencer that drives glitch_free_mux sel from the always-on reference clock.
// Handles software switch requests, settle hold-off and automatic failover.
module clock_switch_ctrl #(
   parameter int   SETTLE_CYCLES = 16,
   parameter logic RESET_SEL     = 1'b0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic       req_sel,
   output logic       req_ready,
   output logic       resp_valid,
   output logic       resp_err,
   input  logic       clka_ok,
   input  logic       clkb_ok,
   input  logic       auto_fo_en,
   output logic       sel,
   output logic       cur_sel,
   output logic       busy,
   output logic       failover_evt,
   output logic [1:0] dbg_state
);

   // Handshake: a request transfers on a rising clock edge where req_valid and
   // req_ready are both high; req_valid must hold until then, and each accepted
   // request gets exactly one resp_valid pulse unless reset intervenes.

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          cur_sel_q, cur_sel_d;
   logic          owed_q, owed_d;
   logic          err_q, err_d;

   logic cur_ok, other_ok, req_ok, tgt_ok, fo;

   always_comb begin
      cur_ok   = cur_sel_q ? clkb_ok : clka_ok;
      other_ok = cur_sel_q ? clka_ok : clkb_ok;
      req_ok   = req_sel   ? clkb_ok : clka_ok;
      tgt_ok   = sel_q     ? clkb_ok : clka_ok;
      fo       = auto_fo_en & ~cur_ok & other_ok;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      cur_sel_d = cur_sel_q;
      owed_d    = owed_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            // Failover has priority; a same-cycle request is left pending.
            if (fo) begin
               sel_d   = ~cur_sel_q;
               cnt_d   = CNT_LOAD;
               owed_d  = 1'b0;
               err_d   = 1'b0;
               state_d = ST_SETTLE;
            end else if (req_valid) begin
               if (req_sel == cur_sel_q) begin
                  owed_d  = 1'b1;
                  err_d   = 1'b0;
                  state_d = ST_RESP;
               end else if (!req_ok) begin
                  owed_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  sel_d   = req_sel;
                  cnt_d   = CNT_LOAD;
                  owed_d  = 1'b1;
                  err_d   = 1'b0;
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (!tgt_ok) err_d = 1'b1;
            if (cnt_q == '0) begin
               cur_sel_d = sel_q;
               if (owed_q) begin
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RESP: begin
            owed_d  = 1'b0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            owed_d  = 1'b0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_SETTLE;
         cnt_q     <= CNT_LOAD;
         sel_q     <= RESET_SEL;
         cur_sel_q <= RESET_SEL;
         owed_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         cur_sel_q <= cur_sel_d;
         owed_q    <= owed_d;
         err_q     <= err_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE) & ~fo;
   assign failover_evt = (state_q == ST_IDLE) & fo;
   assign resp_valid   = (state_q == ST_RESP);
   assign resp_err     = (state_q == ST_RESP) & err_q;
   assign busy         = (state_q != ST_IDLE);
   assign sel          = sel_q;
   assign cur_sel      = cur_sel_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl: reset settle, switch, error, failover
// and mid-settle reset, with hand-computed latencies for SETTLE_CYCLES=16.
module tb_clock_switch_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_sel = 1'b0;
   logic       clka_ok = 1'b1;
   logic       clkb_ok = 1'b1;
   logic       auto_fo_en = 1'b0;
   logic       req_ready, resp_valid, resp_err;
   logic       sel, cur_sel, busy, failover_evt;
   logic [1:0] dbg_state;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int n;
   int lat;
   logic any_resp;

   always #5 clock = ~clock;

   clock_switch_ctrl #(.SETTLE_CYCLES(16), .RESET_SEL(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
      .clka_ok(clka_ok), .clkb_ok(clkb_ok), .auto_fo_en(auto_fo_en),
      .sel(sel), .cur_sel(cur_sel), .busy(busy), .failover_evt(failover_evt),
      .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called right after the accept edge; lat counts sample points from accept.
   task automatic wait_resp(input int start, output int l);
      l = start;
      while (!resp_valid && l < 64) begin
         tick();
         l++;
      end
   endtask

   task automatic switch_to(input logic tgt);
      int l;
      req_valid = 1'b1;
      req_sel   = tgt;
      tick();
      req_valid = 1'b0;
      wait_resp(1, l);
      check_int("sw_latency", l, 18);
      check("sw_err", resp_err, 1'b0);
      check("sw_cur_sel", cur_sel, tgt);
      tick();
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      check("rst_sel", sel, 1'b0);
      check("rst_cur_sel", cur_sel, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_err", resp_err, 1'b0);
      check("rst_failover_evt", failover_evt, 1'b0);

      // initial settle: 17 busy cycles, no response
      reset_n = 1'b1;
      n = 0;
      any_resp = 1'b0;
      while (busy && n < 64) begin
         any_resp |= resp_valid;
         tick();
         n++;
      end
      check_int("init_busy_cycles", n, 17);
      check("init_no_resp", any_resp, 1'b0);
      check("init_req_ready", req_ready, 1'b1);
      check("init_sel", sel, 1'b0);
      check("init_cur_sel", cur_sel, 1'b0);

      // switch A->B
      req_valid = 1'b1;
      req_sel   = 1'b1;
      #1;
      check("ab_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      check("ab_sel_next", sel, 1'b1);
      check("ab_cur_sel_hold", cur_sel, 1'b0);
      check("ab_busy", busy, 1'b1);
      wait_resp(1, lat);
      check_int("ab_latency", lat, 18);
      check("ab_err", resp_err, 1'b0);
      check("ab_cur_sel", cur_sel, 1'b1);
      tick();
      check("ab_resp_one_cycle", resp_valid, 1'b0);
      check("ab_idle", busy, 1'b0);

      switch_to(1'b0);

      // request to a dead target: immediate error, sel unchanged
      clkb_ok   = 1'b0;
      req_valid = 1'b1;
      req_sel   = 1'b1;
      tick();
      req_valid = 1'b0;
      check("err_resp_valid", resp_valid, 1'b1);
      check("err_resp_err", resp_err, 1'b1);
      check("err_sel", sel, 1'b0);
      tick();
      check("err_resp_one_cycle", resp_valid, 1'b0);
      check("err_cur_sel", cur_sel, 1'b0);

      // both dead: no failover, request errors
      clka_ok    = 1'b0;
      auto_fo_en = 1'b1;
      #1;
      check("dead_no_fo", failover_evt, 1'b0);
      check("dead_req_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_sel   = 1'b1;
      tick();
      req_valid = 1'b0;
      check("dead_resp_valid", resp_valid, 1'b1);
      check("dead_resp_err", resp_err, 1'b1);
      check("dead_sel", sel, 1'b0);
      tick();
      clka_ok = 1'b1;
      clkb_ok = 1'b1;

      // no-op request to the current source
      req_valid = 1'b1;
      req_sel   = 1'b0;
      tick();
      req_valid = 1'b0;
      check("noop_resp_valid", resp_valid, 1'b1);
      check("noop_resp_err", resp_err, 1'b0);
      check("noop_sel", sel, 1'b0);
      tick();

      // failover beats a same-cycle request
      clka_ok   = 1'b0;
      req_valid = 1'b1;
      req_sel   = 1'b0;
      #1;
      check("fo_evt", failover_evt, 1'b1);
      check("fo_req_ready", req_ready, 1'b0);
      tick();
      req_valid = 1'b0;
      check("fo_sel", sel, 1'b1);
      check("fo_evt_one_cycle", failover_evt, 1'b0);
      check("fo_busy", busy, 1'b1);
      check("fo_cur_sel_hold", cur_sel, 1'b0);
      n = 0;
      any_resp = 1'b0;
      while (!cur_sel && n < 64) begin
         any_resp |= resp_valid;
         tick();
         n++;
      end
      check_int("fo_cur_sel_delay", n, 17);
      check("fo_no_resp", any_resp, 1'b0);
      check("fo_idle", busy, 1'b0);
      clka_ok    = 1'b1;
      auto_fo_en = 1'b0;

      // target drops mid-settle: switch completes with error
      switch_to(1'b0);
      req_valid = 1'b1;
      req_sel   = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (5) tick();
      clkb_ok = 1'b0;
      repeat (2) tick();
      clkb_ok = 1'b1;
      wait_resp(8, lat);
      check_int("drop_latency", lat, 18);
      check("drop_err", resp_err, 1'b1);
      check("drop_cur_sel", cur_sel, 1'b1);
      check("drop_sel", sel, 1'b1);
      tick();

      // reset mid-settle: sel returns asynchronously, response dropped
      switch_to(1'b0);
      req_valid = 1'b1;
      req_sel   = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      check("mid_sel_before", sel, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_sel", sel, 1'b0);
      check("mid_rst_cur_sel", cur_sel, 1'b0);
      check("mid_rst_busy", busy, 1'b1);
      check("mid_rst_resp_valid", resp_valid, 1'b0);
      repeat (2) tick();
      reset_n = 1'b1;
      n = 0;
      any_resp = 1'b0;
      while (busy && n < 64) begin
         any_resp |= resp_valid;
         tick();
         n++;
      end
      check_int("mid_busy_cycles", n, 17);
      check("mid_no_resp", any_resp, 1'b0);
      check("mid_sel_after", sel, 1'b0);
      check("mid_req_ready", req_ready, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
